// File: rtl/cim_tile_ctrl_if.sv
// Signal bundle between the CIM tile controller and its initiator, crossbar, ADC and output buffer.
// The controller takes the slave view; the initiator side (or a bench) takes the master view.
interface cim_tile_ctrl_if #(
   parameter int XBAR_SIZE  = 128,
   parameter int BUS_WIDTH  = 16,
   parameter int NUM_ADDR   = XBAR_SIZE / BUS_WIDTH,
   parameter int ADDR_WIDTH = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
   parameter int NUM_COLS   = 8,
   parameter int COL_WIDTH  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
   parameter int ADC_WIDTH  = 8
);
   logic                  i_cim_we;
   logic                  i_cim_start;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [BUS_WIDTH-1:0]  i_data;
   logic                  o_cim_ready;
   logic [XBAR_SIZE-1:0]  o_xbar_in;
   logic                  o_xbar_en;
   logic                  o_adc_start;
   logic [COL_WIDTH-1:0]  o_col_sel;
   logic [ADC_WIDTH-1:0]  i_adc_data;
   logic                  o_obuf_we;
   logic [COL_WIDTH-1:0]  o_obuf_addr;
   logic [ADC_WIDTH-1:0]  o_obuf_data;

   modport slave (
      input  i_cim_we, i_cim_start, i_addr, i_data, i_adc_data,
      output o_cim_ready, o_xbar_in, o_xbar_en, o_adc_start, o_col_sel,
             o_obuf_we, o_obuf_addr, o_obuf_data
   );

   modport master (
      output i_cim_we, i_cim_start, i_addr, i_data, i_adc_data,
      input  o_cim_ready, o_xbar_in, o_xbar_en, o_adc_start, o_col_sel,
             o_obuf_we, o_obuf_addr, o_obuf_data
   );
endinterface

// File: rtl/cim_tile_ctrl.sv
// Compute-in-memory tile controller: loads the crossbar row buffer, pulses the row drive,
// then steps the ADC across every column and streams each result into the output buffer.
module cim_tile_ctrl #(
   parameter int XBAR_SIZE  = 128,
   parameter int BUS_WIDTH  = 16,
   parameter int NUM_ADDR   = XBAR_SIZE / BUS_WIDTH,
   parameter int ADDR_WIDTH = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
   parameter int NUM_COLS   = 8,
   parameter int COL_WIDTH  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
   parameter int ADC_WIDTH  = 8,
   parameter int ADC_CYCLES = 2
) (
   input logic            clk,
   input logic            rst,
   cim_tile_ctrl_if.slave bus
);
   localparam int IDX_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
   localparam int PH_W  = (ADC_CYCLES > 1) ? $clog2(ADC_CYCLES) : 1;
   localparam int AW1   = ADDR_WIDTH + 1;
   localparam logic [AW1-1:0]       ADDR_LIMIT = AW1'(NUM_ADDR);
   localparam logic [COL_WIDTH-1:0] LAST_COL   = COL_WIDTH'(NUM_COLS - 1);
   localparam logic [PH_W-1:0]      LAST_PH    = PH_W'(ADC_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      CONVERT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [COL_WIDTH-1:0] col_q;
   logic [PH_W-1:0]      phase_q;
   logic [BUS_WIDTH-1:0] row_buf [NUM_ADDR];
   logic [XBAR_SIZE-1:0] xbar_vec;
   logic                 addr_ok;
   logic                 buf_we;
   logic                 ready, xbar_en, adc_start, obuf_we;
   logic [COL_WIDTH-1:0] col_sel, obuf_addr;
   logic [ADC_WIDTH-1:0] obuf_data;

   // Zero-extend the address so out-of-range words (e.g. 9 of 8) are rejected instead of aliasing.
   assign addr_ok = ({1'b0, bus.i_addr} < ADDR_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CONVERT) begin
            if (phase_q == LAST_PH) begin
               phase_q <= '0;
               col_q   <= col_q + COL_WIDTH'(1);
            end else begin
               phase_q <= phase_q + PH_W'(1);
            end
         end else begin
            col_q   <= '0;
            phase_q <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_ADDR; k++) row_buf[k] <= '0;
      end else if (buf_we) begin
         row_buf[bus.i_addr[IDX_W-1:0]] <= bus.i_data;
      end
   end

   always_comb begin
      xbar_vec = '0;
      for (int k = 0; k < NUM_ADDR; k++) xbar_vec[k*BUS_WIDTH +: BUS_WIDTH] = row_buf[k];
   end

   // A write in the same cycle as a start wins; the start is only taken on a write-free cycle.
   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      xbar_en   = 1'b0;
      adc_start = 1'b0;
      obuf_we   = 1'b0;
      col_sel   = '0;
      obuf_addr = '0;
      obuf_data = '0;
      buf_we    = 1'b0;
      case (state_q)
         IDLE: begin
            ready  = 1'b1;
            buf_we = bus.i_cim_we && addr_ok;
            if (bus.i_cim_start && !bus.i_cim_we) state_d = APPLY;
         end
         APPLY: begin
            xbar_en = 1'b1;
            state_d = CONVERT;
         end
         CONVERT: begin
            col_sel   = col_q;
            adc_start = (phase_q == '0);
            if (phase_q == LAST_PH) begin
               obuf_we   = 1'b1;
               obuf_addr = col_q;
               obuf_data = bus.i_adc_data;
               if (col_q == LAST_COL) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_cim_ready = ready;
   assign bus.o_xbar_in   = xbar_vec;
   assign bus.o_xbar_en   = xbar_en;
   assign bus.o_adc_start = adc_start;
   assign bus.o_col_sel   = col_sel;
   assign bus.o_obuf_we   = obuf_we;
   assign bus.o_obuf_addr = obuf_addr;
   assign bus.o_obuf_data = obuf_data;
endmodule

// File: tb/tb_cim_tile_ctrl.sv
// Bench for cim_tile_ctrl: a default-timing tile (address widened to reach word 9) and a
// single-cycle-ADC four-column tile, with output-buffer writes checked against a queue of expected writes.
module tb_cim_tile_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      int         cyc;
      logic [7:0] addr;
      logic [7:0] data;
      logic       adc_start;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   cim_tile_ctrl_if #(.ADDR_WIDTH(4)) bus0 ();
   cim_tile_ctrl_if #(.NUM_COLS(4))   bus1 ();

   cim_tile_ctrl #(.ADDR_WIDTH(4)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   cim_tile_ctrl #(.NUM_COLS(4), .ADC_CYCLES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ADC stand-in: result is 8'h10 plus the selected column.
   assign bus0.i_adc_data = 8'h10 + 8'(bus0.o_col_sel);
   assign bus1.i_adc_data = 8'h10 + 8'(bus1.o_col_sel);

   task automatic checkOutput(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic checkVector(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input int which, input logic we, input logic start,
                                input logic [3:0] addr, input logic [15:0] data);
      #1;
      if (which == 0) begin
         bus0.i_cim_we    = we;
         bus0.i_cim_start = start;
         bus0.i_addr      = addr;
         bus0.i_data      = data;
      end else begin
         bus1.i_cim_we    = we;
         bus1.i_cim_start = start;
         bus1.i_addr      = addr[2:0];
         bus1.i_data      = data;
      end
   endtask

   task automatic pushExpect(input int which, input int at, input int col, input logic adc);
      exp_t e;
      e.cyc       = at;
      e.addr      = 8'(col);
      e.data      = 8'h10 + 8'(col);
      e.adc_start = adc;
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
   endtask

   // Monitor: every output-buffer write must match the oldest expected write for that tile.
   always @(negedge clk) begin
      exp_t e;
      if (bus0.o_obuf_we !== 1'b0) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("[TB] FAIL obuf0 unexpected: got we=%b addr=%0d data=%h at cycle %0d, required no write",
                     bus0.o_obuf_we, bus0.o_obuf_addr, bus0.o_obuf_data, cyc);
         end else begin
            e = q0.pop_front();
            if (e.cyc != cyc || e.addr != 8'(bus0.o_obuf_addr) || e.data != bus0.o_obuf_data ||
                e.adc_start != bus0.o_adc_start) begin
               errors++;
               $display("[TB] FAIL obuf0 write: got cyc=%0d addr=%0d data=%h adc=%b, required cyc=%0d addr=%0d data=%h adc=%b",
                        cyc, bus0.o_obuf_addr, bus0.o_obuf_data, bus0.o_adc_start,
                        e.cyc, e.addr, e.data, e.adc_start);
            end
         end
      end
      if (bus1.o_obuf_we !== 1'b0) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("[TB] FAIL obuf1 unexpected: got we=%b addr=%0d data=%h at cycle %0d, required no write",
                     bus1.o_obuf_we, bus1.o_obuf_addr, bus1.o_obuf_data, cyc);
         end else begin
            e = q1.pop_front();
            if (e.cyc != cyc || e.addr != 8'(bus1.o_obuf_addr) || e.data != bus1.o_obuf_data ||
                e.adc_start != bus1.o_adc_start) begin
               errors++;
               $display("[TB] FAIL obuf1 write: got cyc=%0d addr=%0d data=%h adc=%b, required cyc=%0d addr=%0d data=%h adc=%b",
                        cyc, bus1.o_obuf_addr, bus1.o_obuf_data, bus1.o_adc_start,
                        e.cyc, e.addr, e.data, e.adc_start);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] exp_x;
      int           t;

      rst = 1'b1;
      bus0.i_cim_we = 1'b0; bus0.i_cim_start = 1'b0; bus0.i_addr = '0; bus0.i_data = '0;
      bus1.i_cim_we = 1'b0; bus1.i_cim_start = 1'b0; bus1.i_addr = '0; bus1.i_data = '0;
      repeat (2) @(posedge clk);

      @(negedge clk);
      checkOutput("reset ready0", bus0.o_cim_ready, 1'b1);
      checkOutput("reset xbar_en0", bus0.o_xbar_en, 1'b0);
      checkOutput("reset adc_start0", bus0.o_adc_start, 1'b0);
      checkOutput("reset obuf_we0", bus0.o_obuf_we, 1'b0);
      checkVector("reset xbar_in0", bus0.o_xbar_in, 128'(0));
      checkVector("reset col_sel0", 128'(bus0.o_col_sel), 128'(0));
      checkOutput("reset ready1", bus1.o_cim_ready, 1'b1);
      checkVector("reset xbar_in1", bus1.o_xbar_in, 128'(0));
      #1 rst = 1'b0;

      // Load word k with a single bit k, then try an out-of-range write to word 9.
      exp_x = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         applyStimulus(0, 1'b1, 1'b0, 4'(k), 16'(1 << k));
         exp_x[k*17] = 1'b1;
      end
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0, 4'd9, 16'hFFFF);
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0, 4'd0, 16'h0000);
      @(negedge clk);
      checkVector("load xbar_in", bus0.o_xbar_in, exp_x);

      // Full operation on the default tile, with write/start pulses while busy.
      @(negedge clk);
      t = cyc;
      for (int c = 0; c < 8; c++) pushExpect(0, t + 3 + 2*c, c, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 4'd0, 16'h0000);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         checkOutput($sformatf("op1 ready n=%0d", n), bus0.o_cim_ready, (n <= 18) ? 1'b0 : 1'b1);
         checkOutput($sformatf("op1 xbar_en n=%0d", n), bus0.o_xbar_en, (n == 1));
         if (n == 1)      applyStimulus(0, 1'b0, 1'b0, 4'd0, 16'h0000);
         else if (n == 4) applyStimulus(0, 1'b1, 1'b1, 4'd0, 16'hFFFF);
         else if (n == 5) applyStimulus(0, 1'b0, 1'b0, 4'd0, 16'h0000);
         else if (n == 8) applyStimulus(0, 1'b1, 1'b1, 4'd2, 16'h5555);
         else if (n == 9) applyStimulus(0, 1'b0, 1'b0, 4'd0, 16'h0000);
      end
      checkVector("op1 xbar_in kept", bus0.o_xbar_in, exp_x);

      // Write and start together: write lands, start waits one cycle.
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b1, 4'd3, 16'hABCD);
      @(negedge clk);
      exp_x[63:48] = 16'hABCD;
      checkOutput("we+start ready", bus0.o_cim_ready, 1'b1);
      checkVector("we+start xbar_in", bus0.o_xbar_in, exp_x);
      t = cyc;
      pushExpect(0, t + 3, 0, 1'b0);
      pushExpect(0, t + 5, 1, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 4'd0, 16'h0000);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         checkOutput($sformatf("op2 ready n=%0d", n), bus0.o_cim_ready, (n <= 6) ? 1'b0 : 1'b1);
         checkOutput($sformatf("op2 xbar_en n=%0d", n), bus0.o_xbar_en, (n == 1));
         if (n >= 7) begin
            checkOutput($sformatf("op2 obuf_we n=%0d", n), bus0.o_obuf_we, 1'b0);
            checkVector($sformatf("op2 xbar_in n=%0d", n), bus0.o_xbar_in, 128'(0));
         end
         if (n == 1) applyStimulus(0, 1'b0, 1'b0, 4'd0, 16'h0000);
         if (n == 6) #1 rst = 1'b1;
         if (n == 7) #1 rst = 1'b0;
      end

      // Single-cycle ADC, four columns: start and write coincide every CONVERT cycle.
      @(negedge clk);
      applyStimulus(1, 1'b1, 1'b0, 4'd0, 16'h00FF);
      @(negedge clk);
      t = cyc;
      for (int c = 0; c < 4; c++) pushExpect(1, t + 2 + c, c, 1'b1);
      applyStimulus(1, 1'b0, 1'b1, 4'd0, 16'h0000);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         checkOutput($sformatf("op3 ready n=%0d", n), bus1.o_cim_ready, (n <= 6) ? 1'b0 : 1'b1);
         checkOutput($sformatf("op3 adc_start n=%0d", n), bus1.o_adc_start, (n >= 2 && n <= 5));
         checkOutput($sformatf("op3 obuf_we n=%0d", n), bus1.o_obuf_we, (n >= 2 && n <= 5));
         checkVector($sformatf("op3 col_sel n=%0d", n), 128'(bus1.o_col_sel),
                     (n >= 2 && n <= 5) ? 128'(n - 2) : 128'(0));
         if (n == 1) applyStimulus(1, 1'b0, 1'b0, 4'd0, 16'h0000);
      end
      checkVector("op3 xbar_in", bus1.o_xbar_in, 128'h00FF);

      repeat (3) @(negedge clk);
      checkVector("queue0 drained", 128'(q0.size()), 128'(0));
      checkVector("queue1 drained", 128'(q1.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
